// File: rtl/st7735_rx_if.sv
// Bundle between the ST7735 SPI pins and the decoded command/pixel stream.
// ERR joins the bundle only when ST7735_RX_ERR_EN is defined.
interface st7735_rx_if #(
  parameter int COORD_W = 8
);
  logic               CS;
  logic               MOSI;
  logic               DC;
  logic               LCD_CLK;
  logic               CMD_VALID;
  logic [7:0]         CMD_BYTE;
  logic               PIX_VALID;
  logic [COORD_W-1:0] PIX_X;
  logic [COORD_W-1:0] PIX_Y;
  logic [15:0]        PIX_DATA;
  logic               FRAME_DONE;
`ifdef ST7735_RX_ERR_EN
  logic               ERR;
`endif

  modport master (
`ifdef ST7735_RX_ERR_EN
    input  ERR,
`endif
    output CS,
    output MOSI,
    output DC,
    output LCD_CLK,
    input  CMD_VALID,
    input  CMD_BYTE,
    input  PIX_VALID,
    input  PIX_X,
    input  PIX_Y,
    input  PIX_DATA,
    input  FRAME_DONE
  );

  modport slave (
`ifdef ST7735_RX_ERR_EN
    output ERR,
`endif
    input  CS,
    input  MOSI,
    input  DC,
    input  LCD_CLK,
    output CMD_VALID,
    output CMD_BYTE,
    output PIX_VALID,
    output PIX_X,
    output PIX_Y,
    output PIX_DATA,
    output FRAME_DONE
  );
endinterface

// File: rtl/st7735_rx.sv
// ST7735 4-wire SPI receiver: byte reassembly plus CASET/RASET/RAMWR/SWRESET decode.
// Optional sticky protocol-error flag enabled with ST7735_RX_ERR_EN.
module st7735_rx #(
  parameter int WIDTH       = 128,
  parameter int HEIGHT      = 160,
  parameter int COORD_W     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         SYSTEM_CLK,
  input  logic         RESET,
  st7735_rx_if.slave   bus
);

  localparam logic [15:0] XE_RST = 16'(WIDTH - 1);
  localparam logic [15:0] YE_RST = 16'(HEIGHT - 1);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_CA0  = 4'd1;
  localparam logic [3:0] S_CA1  = 4'd2;
  localparam logic [3:0] S_CA2  = 4'd3;
  localparam logic [3:0] S_CA3  = 4'd4;
  localparam logic [3:0] S_RA0  = 4'd5;
  localparam logic [3:0] S_RA1  = 4'd6;
  localparam logic [3:0] S_RA2  = 4'd7;
  localparam logic [3:0] S_RA3  = 4'd8;
  localparam logic [3:0] S_HI   = 4'd9;
  localparam logic [3:0] S_LO   = 4'd10;

  // all four pins share one synchroniser depth so data stays aligned to the clock
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES-1:0] dc_q;
  logic [SYNC_STAGES-1:0] sck_q;
  logic                   sck_d;

  always_ff @(posedge SYSTEM_CLK) begin
    if (RESET) begin
      cs_q   <= '0;
      mosi_q <= '0;
      dc_q   <= '0;
      sck_q  <= '0;
      sck_d  <= 1'b0;
    end else begin
      cs_q   <= {cs_q[SYNC_STAGES-2:0], bus.CS};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.MOSI};
      dc_q   <= {dc_q[SYNC_STAGES-2:0], bus.DC};
      sck_q  <= {sck_q[SYNC_STAGES-2:0], bus.LCD_CLK};
      sck_d  <= sck_q[SYNC_STAGES-1];
    end
  end

  logic cs_s;
  logic mosi_s;
  logic dc_s;
  logic rise;

  assign cs_s   = cs_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign dc_s   = dc_q[SYNC_STAGES-1];
  assign rise   = sck_q[SYNC_STAGES-1] & ~sck_d;

  logic [2:0] bitcnt;
  logic [6:0] shreg;
  logic       byte_vld;
  logic [7:0] byte_val;
  logic       byte_dc;

  always_ff @(posedge SYSTEM_CLK) begin
    if (RESET) begin
      bitcnt   <= 3'd0;
      shreg    <= 7'd0;
      byte_vld <= 1'b0;
      byte_val <= 8'd0;
      byte_dc  <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      if (cs_s) begin
        bitcnt <= 3'd0;
      end else if (rise) begin
        bitcnt <= bitcnt + 3'd1;
        shreg  <= {shreg[5:0], mosi_s};
        if (bitcnt == 3'd7) begin
          byte_vld <= 1'b1;
          byte_val <= {shreg, mosi_s};
          byte_dc  <= dc_s;
        end
      end
    end
  end

  logic [3:0]  state;
  logic [15:0] xs;
  logic [15:0] xe;
  logic [15:0] ys;
  logic [15:0] ye;
  logic [15:0] cur_x;
  logic [15:0] cur_y;
  logic [7:0]  p0;
  logic [7:0]  p1;
  logic [7:0]  p2;
  logic [7:0]  hi_byte;

  logic               cmd_valid;
  logic [7:0]         cmd_byte;
  logic               pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [15:0]        pix_data;
  logic               frame_done;

  logic        is_cmd;
  logic        is_dat;
  logic        is_caset;
  logic        is_raset;
  logic        is_ramwr;
  logic        is_swrst;
  logic [15:0] w_start;
  logic [15:0] w_end;
  logic [15:0] w_endf;
  logic        at_xe;
  logic        at_ye;

  assign is_cmd   = byte_vld & ~byte_dc;
  assign is_dat   = byte_vld & byte_dc;
  assign is_caset = byte_val == 8'h2A;
  assign is_raset = byte_val == 8'h2B;
  assign is_ramwr = byte_val == 8'h2C;
  assign is_swrst = byte_val == 8'h01;
  assign w_start  = {p0, p1};
  assign w_end    = {p2, byte_val};
  // an inverted window collapses to a single line at the start coordinate
  assign w_endf   = (w_start > w_end) ? w_start : w_end;
  assign at_xe    = cur_x >= xe;
  assign at_ye    = cur_y >= ye;

  always_ff @(posedge SYSTEM_CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      xs         <= 16'd0;
      xe         <= XE_RST;
      ys         <= 16'd0;
      ye         <= YE_RST;
      cur_x      <= 16'd0;
      cur_y      <= 16'd0;
      p0         <= 8'd0;
      p1         <= 8'd0;
      p2         <= 8'd0;
      hi_byte    <= 8'd0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= 8'd0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= 16'd0;
      frame_done <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (is_cmd) begin
        cmd_valid <= 1'b1;
        cmd_byte  <= byte_val;
        state     <= S_IDLE;
        unique case (1'b1)
          is_caset: state <= S_CA0;
          is_raset: state <= S_RA0;
          is_ramwr: begin
            state <= S_HI;
            cur_x <= xs;
            cur_y <= ys;
          end
          is_swrst: begin
            xs <= 16'd0;
            xe <= XE_RST;
            ys <= 16'd0;
            ye <= YE_RST;
          end
          default: ;
        endcase
      end else if (is_dat) begin
        case (state)
          S_CA0, S_RA0: begin
            p0    <= byte_val;
            state <= state + 4'd1;
          end
          S_CA1, S_RA1: begin
            p1    <= byte_val;
            state <= state + 4'd1;
          end
          S_CA2, S_RA2: begin
            p2    <= byte_val;
            state <= state + 4'd1;
          end
          S_CA3: begin
            xs    <= w_start;
            xe    <= w_endf;
            state <= S_IDLE;
          end
          S_RA3: begin
            ys    <= w_start;
            ye    <= w_endf;
            state <= S_IDLE;
          end
          S_HI: begin
            hi_byte <= byte_val;
            state   <= S_LO;
          end
          S_LO: begin
            pix_valid <= 1'b1;
            pix_x     <= cur_x[COORD_W-1:0];
            pix_y     <= cur_y[COORD_W-1:0];
            pix_data  <= {hi_byte, byte_val};
            state     <= S_HI;
            if (!at_xe) begin
              cur_x <= cur_x + 16'd1;
            end else if (!at_ye) begin
              cur_x <= xs;
              cur_y <= cur_y + 16'd1;
            end else begin
              cur_x      <= xs;
              cur_y      <= ys;
              frame_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.CMD_VALID  = cmd_valid;
  assign bus.CMD_BYTE   = cmd_byte;
  assign bus.PIX_VALID  = pix_valid;
  assign bus.PIX_X      = pix_x;
  assign bus.PIX_Y      = pix_y;
  assign bus.PIX_DATA   = pix_data;
  assign bus.FRAME_DONE = frame_done;

`ifdef ST7735_RX_ERR_EN
  logic err;
  logic err_cs;
  logic err_cmd;

  assign err_cs  = cs_s & (bitcnt != 3'd0);
  assign err_cmd = is_cmd & (state == S_CA1 || state == S_CA2 ||
                             state == S_CA3 || state == S_RA1 ||
                             state == S_RA2 || state == S_RA3 ||
                             state == S_LO);

  always_ff @(posedge SYSTEM_CLK) begin
    if (RESET) begin
      err <= 1'b0;
    end else if (err_cs || err_cmd) begin
      err <= 1'b1;
    end
  end

  assign bus.ERR = err;
`endif

endmodule

// File: tb/tb_st7735_rx.sv
// Directed bench for st7735_rx: byte/command decode, windows, aborts, resets.
`timescale 1ns/1ps
module tb_st7735_rx;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  st7735_rx_if #(.COORD_W(8)) bus ();

  st7735_rx #(
    .WIDTH(128),
    .HEIGHT(160),
    .COORD_W(8),
    .SYNC_STAGES(2)
  ) dut (
    .SYSTEM_CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] d;
    logic        fd;
  } pix_t;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        fd;
  } vec_t;

  pix_t       pq[$];
  logic [7:0] cq[$];
  int         stray = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always @(negedge clk) begin
    if (bus.PIX_VALID)
      pq.push_back({bus.PIX_X, bus.PIX_Y, bus.PIX_DATA, bus.FRAME_DONE});
    if (bus.CMD_VALID)
      cq.push_back(bus.CMD_BYTE);
    if (bus.FRAME_DONE && !bus.PIX_VALID)
      stray++;
  end

  task automatic chk(input string nm, input logic [39:0] act,
                     input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic dc, input logic b);
    bus.MOSI = b;
    bus.DC   = dc;
    tick(2);
    bus.LCD_CLK = 1'b1;
    tick(2);
    bus.LCD_CLK = 1'b0;
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    for (int i = 7; i >= 0; i--)
      send_bit(dc, b[i]);
  endtask

  task automatic send4(input logic [7:0] c, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] e,
                       input logic [7:0] f);
    send_byte(1'b0, c);
    send_byte(1'b1, a);
    send_byte(1'b1, b);
    send_byte(1'b1, e);
    send_byte(1'b1, f);
  endtask

  task automatic send_pix(input logic [15:0] d);
    send_byte(1'b1, d[15:8]);
    send_byte(1'b1, d[7:0]);
  endtask

  task automatic settle();
    tick(10);
  endtask

  task automatic reset_dut();
    bus.CS      = 1'b1;
    bus.LCD_CLK = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    pq.delete();
    cq.delete();
    bus.CS = 1'b0;
    tick(4);
  endtask

  task automatic expect_pix(input string nm, input logic [7:0] x,
                            input logic [7:0] y, input logic [15:0] d,
                            input logic fd);
    pix_t p;
    if (pq.size() == 0) begin
      chk({nm, "_missing"}, 40'd0, 40'd1);
    end else begin
      p = pq.pop_front();
      chk(nm, 40'(p), 40'({x, y, d, fd}));
    end
  endtask

  task automatic expect_cmd(input string nm, input logic [7:0] c);
    chk({nm, "_count"}, 40'(cq.size()), 40'd1);
    if (cq.size() != 0)
      chk({nm, "_byte"}, 40'(cq.pop_front()), 40'(c));
    chk({nm, "_held"}, 40'(bus.CMD_BYTE), 40'(c));
    cq.delete();
  endtask

  vec_t       win[4];
  logic [7:0] cmds[4];
  int         lat;

  initial begin
    win[0] = '{16'hA001, 8'd2, 8'd5, 1'b0};
    win[1] = '{16'hA002, 8'd3, 8'd5, 1'b1};
    win[2] = '{16'hA003, 8'd2, 8'd5, 1'b0};
    win[3] = '{16'hA004, 8'd3, 8'd5, 1'b1};
    cmds[0] = 8'h55;
    cmds[1] = 8'h2A;
    cmds[2] = 8'h00;
    cmds[3] = 8'hFF;

    rst = 1'b1;
    bus.CS = 1'b1;
    bus.MOSI = 1'b0;
    bus.DC = 1'b0;
    bus.LCD_CLK = 1'b0;
    tick(3);
    chk("rst_cmd_valid", 40'(bus.CMD_VALID), 40'd0);
    chk("rst_cmd_byte", 40'(bus.CMD_BYTE), 40'd0);
    chk("rst_pix_valid", 40'(bus.PIX_VALID), 40'd0);
    chk("rst_pix_xy", 40'({bus.PIX_X, bus.PIX_Y}), 40'd0);
    chk("rst_pix_data", 40'(bus.PIX_DATA), 40'd0);
    chk("rst_frame_done", 40'(bus.FRAME_DONE), 40'd0);
`ifdef ST7735_RX_ERR_EN
    chk("rst_err", 40'(bus.ERR), 40'd0);
`endif
    reset_dut();

    send_byte(1'b0, 8'h2C);
    send_pix(16'hF800);
    settle();
    expect_pix("first_pix", 8'd0, 8'd0, 16'hF800, 1'b0);
    cq.delete();

    // latency from the pin rise carrying the last bit of 0x2A
    for (int i = 7; i >= 1; i--)
      send_bit(1'b0, cmds[1][i]);
    bus.MOSI = 1'b0;
    bus.DC = 1'b0;
    tick(2);
    bus.LCD_CLK = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.CMD_VALID) begin
        lat = k;
        break;
      end
    end
    chk("cmd_latency", 40'(lat), 40'd4);
    tick(1);
    bus.LCD_CLK = 1'b0;
    settle();
    expect_cmd("cmd_2a", 8'h2A);

    for (int i = 0; i < 4; i++) begin
      send_byte(1'b0, cmds[i]);
      settle();
      expect_cmd($sformatf("cmd_tab%0d", i), cmds[i]);
    end
    chk("cmd_no_pix", 40'(pq.size()), 40'd0);
`ifdef ST7735_RX_ERR_EN
    chk("err_clean", 40'(bus.ERR), 40'd0);
`endif

    reset_dut();
    send4(8'h2A, 8'd0, 8'd2, 8'd0, 8'd3);
    send4(8'h2B, 8'd0, 8'd5, 8'd0, 8'd5);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 4; i++) begin
      send_pix(win[i].d);
      settle();
      expect_pix($sformatf("win_pix%0d", i), win[i].x, win[i].y,
                 win[i].d, win[i].fd);
    end

    reset_dut();
    send4(8'h2A, 8'd0, 8'd9, 8'd0, 8'd4);
    send_byte(1'b0, 8'h2C);
    send_pix(16'h07E0);
    send_pix(16'h001F);
    settle();
    expect_pix("inv_pix0", 8'd9, 8'd0, 16'h07E0, 1'b0);
    expect_pix("inv_pix1", 8'd9, 8'd1, 16'h001F, 1'b0);

    reset_dut();
    for (int i = 0; i < 5; i++)
      send_bit(1'b0, 1'b1);
    bus.CS = 1'b1;
    tick(8);
    bus.CS = 1'b0;
    tick(4);
    send_byte(1'b0, 8'h2C);
    settle();
    expect_cmd("abort_cmd", 8'h2C);
`ifdef ST7735_RX_ERR_EN
    chk("abort_err", 40'(bus.ERR), 40'd1);
`endif
    send_byte(1'b1, 8'hAB);
    send_byte(1'b0, 8'h00);
    settle();
    chk("odd_no_pix", 40'(pq.size()), 40'd0);
    expect_cmd("odd_cmd", 8'h00);
    send_byte(1'b0, 8'h2C);
    send_pix(16'h1234);
    settle();
    expect_pix("after_odd", 8'd0, 8'd0, 16'h1234, 1'b0);
    cq.delete();

    reset_dut();
    send4(8'h2A, 8'd0, 8'd2, 8'd0, 8'd3);
    send4(8'h2B, 8'd0, 8'd5, 8'd0, 8'd5);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h77);
    settle();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_cmd_byte", 40'(bus.CMD_BYTE), 40'd0);
    send_byte(1'b1, 8'h88);
    settle();
    chk("midrst_no_pix", 40'(pq.size()), 40'd0);
`ifdef ST7735_RX_ERR_EN
    chk("midrst_err", 40'(bus.ERR), 40'd0);
`endif
    cq.delete();

    // column fixed at 127: rows must run 0..159 with the frame ending on 159
    send4(8'h2A, 8'd0, 8'd127, 8'd0, 8'd127);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 160; i++)
      send_pix(16'(i + 16'h100));
    settle();
    chk("ye_count", 40'(pq.size()), 40'd160);
    for (int i = 0; i < 160; i++)
      expect_pix($sformatf("ye_pix%0d", i), 8'd127, 8'(i),
                 16'(i + 16'h100), i == 159);

    send_byte(1'b0, 8'h01);
    send4(8'h2B, 8'd0, 8'd0, 8'd0, 8'd0);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 129; i++)
      send_pix(16'(i + 16'h4000));
    settle();
    chk("xe_count", 40'(pq.size()), 40'd129);
    for (int i = 0; i < 129; i++)
      expect_pix($sformatf("xe_pix%0d", i), 8'(i % 128), 8'd0,
                 16'(i + 16'h4000), i == 127);

    chk("stray_frame_done", 40'(stray), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
